// File: rtl/gate_pair_monitor.sv
// rtl/gate_pair_monitor.sv - complementary gate pair checker: PWM rebuild, dead-time measurement, sticky faults
module gate_pair_monitor #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                gate_A,
  input  logic                gate_B,
  input  logic                logic_A,
  input  logic                logic_B,
  input  logic                enable,
  input  logic [DT_WIDTH-1:0] dtime_min,
  input  logic                clear_fault,
  output logic                pwm_rec,
  output logic [DT_WIDTH-1:0] dt_AB,
  output logic [DT_WIDTH-1:0] dt_BA,
  output logic                dt_valid_AB,
  output logic                dt_valid_BA,
  output logic                fault_overlap,
  output logic                fault_short_dt,
  output logic                fault
);

  typedef enum logic [2:0] {
    ST_INIT, ST_A_ON, ST_DT_AB, ST_B_ON, ST_DT_BA, ST_FAULT
  } state_t;

  localparam logic [DT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

  state_t              state;
  logic [DT_WIDTH-1:0] cnt;
  logic                a_m, b_m, a_s, b_s;

  // Gate levels are normalised to active-high before crossing into clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_m <= 1'b0;
      b_m <= 1'b0;
      a_s <= 1'b0;
      b_s <= 1'b0;
    end else begin
      a_m <= gate_A ^ logic_A;
      b_m <= gate_B ^ logic_B;
      a_s <= a_m;
      b_s <= b_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_INIT;
      cnt            <= '0;
      dt_AB          <= '0;
      dt_BA          <= '0;
      dt_valid_AB    <= 1'b0;
      dt_valid_BA    <= 1'b0;
      fault_overlap  <= 1'b0;
      fault_short_dt <= 1'b0;
    end else begin
      dt_valid_AB <= 1'b0;
      dt_valid_BA <= 1'b0;
      // Clear is applied first so that any fault set below in the same cycle wins.
      if (clear_fault && (state != ST_FAULT || (!a_s && !b_s))) begin
        fault_overlap  <= 1'b0;
        fault_short_dt <= 1'b0;
      end
      if (!enable) begin
        state <= ST_INIT;
        cnt   <= '0;
      end else if (a_s && b_s) begin
        fault_overlap <= 1'b1;
        state         <= ST_FAULT;
        cnt           <= '0;
      end else begin
        case (state)
          ST_INIT: begin
            if (a_s)      state <= ST_A_ON;
            else if (b_s) state <= ST_B_ON;
          end
          ST_A_ON: begin
            if (!a_s && b_s) begin
              dt_AB       <= '0;
              dt_valid_AB <= 1'b1;
              if (dtime_min != '0) fault_short_dt <= 1'b1;
              state       <= ST_B_ON;
            end else if (!a_s) begin
              cnt   <= CNT_ONE;
              state <= ST_DT_AB;
            end
          end
          ST_DT_AB: begin
            if (b_s) begin
              dt_AB       <= cnt;
              dt_valid_AB <= 1'b1;
              if (cnt < dtime_min) fault_short_dt <= 1'b1;
              cnt         <= '0;
              state       <= ST_B_ON;
            end else if (a_s) begin
              cnt   <= '0;
              state <= ST_A_ON;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_B_ON: begin
            if (!b_s && a_s) begin
              dt_BA       <= '0;
              dt_valid_BA <= 1'b1;
              if (dtime_min != '0) fault_short_dt <= 1'b1;
              state       <= ST_A_ON;
            end else if (!b_s) begin
              cnt   <= CNT_ONE;
              state <= ST_DT_BA;
            end
          end
          ST_DT_BA: begin
            if (a_s) begin
              dt_BA       <= cnt;
              dt_valid_BA <= 1'b1;
              if (cnt < dtime_min) fault_short_dt <= 1'b1;
              cnt         <= '0;
              state       <= ST_A_ON;
            end else if (b_s) begin
              cnt   <= '0;
              state <= ST_B_ON;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_FAULT: begin
            if (clear_fault && !a_s && !b_s) state <= ST_INIT;
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  // The command is high from B turning off until A turns off.
  assign pwm_rec = (state == ST_A_ON) || (state == ST_DT_BA);
  assign fault   = fault_overlap | fault_short_dt;

endmodule
